// File: rtl/input_mems_pkg.sv
// input_mems_pkg: shared state encodings for the ping-pong matrix input loader.
package input_mems_pkg;
    typedef enum logic [1:0] {IDLE, LOAD_A, LOAD_B} loader_state_t;
    typedef enum logic {FREE, FULL} slot_state_t;
endpackage

// File: rtl/input_mems_pp_if.sv
// input_mems_pp_if: AXIS load port and compute-side read port of input_mems_pp.
// k_error exists only when INPUT_MEMS_KCHECK_EN is defined.
interface input_mems_pp_if #(
    parameter int INW = 12,
    parameter int K_BITS = 4,
    parameter int A_ADDR_BITS = 6,
    parameter int B_ADDR_BITS = 7
);
    logic [INW-1:0] AXIS_TDATA;
    logic AXIS_TVALID;
    logic [K_BITS:0] AXIS_TUSER;
    logic AXIS_TREADY;
    logic matrices_loaded;
    logic compute_finished;
    logic [K_BITS-1:0] K;
    logic [A_ADDR_BITS-1:0] A_read_addr;
    logic signed [INW-1:0] A_data;
    logic [B_ADDR_BITS-1:0] B_read_addr;
    logic signed [INW-1:0] B_data;
`ifdef INPUT_MEMS_KCHECK_EN
    logic k_error;
`endif
    modport slave(
        input AXIS_TDATA, AXIS_TVALID, AXIS_TUSER, compute_finished, A_read_addr, B_read_addr,
        output AXIS_TREADY, matrices_loaded, K, A_data, B_data
`ifdef INPUT_MEMS_KCHECK_EN
        , output k_error
`endif
    );
    modport master(
        output AXIS_TDATA, AXIS_TVALID, AXIS_TUSER, compute_finished, A_read_addr, B_read_addr,
        input AXIS_TREADY, matrices_loaded, K, A_data, B_data
`ifdef INPUT_MEMS_KCHECK_EN
        , input k_error
`endif
    );
endinterface

// File: rtl/input_mems_pp_mem.sv
// input_mems_pp_mem: two-bank word store, bank index in the address MSB; registered read.
module input_mems_pp_mem #(
    parameter int W = 12,
    parameter int DEPTH = 112,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic clk,
    input  logic reset,
    input  logic we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [W-1:0] wdata_i,
    input  logic re_i,
    input  logic [AW-1:0] raddr_i,
    output logic [W-1:0] rdata_o
);
    // Banks are padded to a power of two so the bank bit can sit in the MSB.
    logic [W-1:0] mem_q [2**AW];
    always_ff @(posedge clk) begin
        if (we_i) mem_q[waddr_i] <= wdata_i;
        if (reset) rdata_o <= '0;
        else if (re_i) rdata_o <= mem_q[raddr_i];
    end
endmodule

// File: rtl/input_mems_pp.sv
// input_mems_pp: ping-pong A/B matrix store loaded over AXI-Stream, with A reuse across problems.
// Define INPUT_MEMS_KCHECK_EN to reject bad headers with a k_error pulse instead of clamping them.
module input_mems_pp
    import input_mems_pkg::*;
#(
    parameter int INW = 12,
    parameter int M = 7,
    parameter int N = 9,
    parameter int MAXK = 8
) (
    input logic clk,
    input logic reset,
    input_mems_pp_if.slave bus
);
    localparam int K_BITS = $clog2(MAXK + 1);
    localparam int A_ADDR_BITS = $clog2(M * MAXK);
    localparam int B_ADDR_BITS = $clog2(MAXK * N);
    localparam int CW = A_ADDR_BITS > B_ADDR_BITS ? A_ADDR_BITS : B_ADDR_BITS;

    loader_state_t state_q, state_d;
    slot_state_t slot_st_q [2], slot_st_d [2];
    logic [K_BITS-1:0] slot_k_q [2], slot_k_d [2];
    logic [K_BITS-1:0] bank_k_q [2], bank_k_d [2];
    logic [1:0] slot_src_q, slot_src_d, a_valid_q, a_valid_d;
    logic lslot_q, lslot_d, cslot_q, cslot_d, last_src_q, last_src_d, cur_src_q, cur_src_d;
    logic loaded_q, loaded_d, k_error_q, k_error_d;
    logic [K_BITS-1:0] cur_k_q, cur_k_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic [K_BITS-1:0] tk, tk_fix, hk, wk;
    logic tnew, hnew, hsrc, wsrc, w_is_a, idle, rdy, acc, wr, a_last, b_last, hdr_bad;
    logic [CW-1:0] waddr;
    logic [INW-1:0] a_rdata, b_rdata;

    assign tk = bus.AXIS_TUSER[K_BITS:1];
    assign tnew = bus.AXIS_TUSER[0];
    assign idle = state_q == IDLE;
    assign rdy = slot_st_q[lslot_q] == FREE;
    assign acc = bus.AXIS_TVALID && rdy;
    assign tk_fix = tk == '0 ? K_BITS'(1) : (tk > K_BITS'(MAXK) ? K_BITS'(MAXK) : tk);
    // Reuse falls back to a fresh A load when no completed A exists yet.
    assign hnew = tnew || a_valid_q == '0;
    assign hk = hnew ? tk_fix : bank_k_q[last_src_q];
    assign hsrc = !hnew ? last_src_q :
                  slot_st_q[!lslot_q] == FULL ? !slot_src_q[!lslot_q] : lslot_q;
`ifdef INPUT_MEMS_KCHECK_EN
    assign hdr_bad = tnew ? (tk == '0 || tk > K_BITS'(MAXK)) : a_valid_q == '0;
`else
    assign hdr_bad = 1'b0;
`endif
    assign wk = idle ? hk : cur_k_q;
    assign wsrc = idle ? hsrc : cur_src_q;
    assign w_is_a = idle ? hnew : state_q == LOAD_A;
    assign waddr = idle ? '0 : cnt_q;
    assign wr = acc && !(idle && hdr_bad);
    assign a_last = w_is_a && 32'(waddr) == 32'(M) * 32'(wk) - 32'd1;
    assign b_last = !w_is_a && 32'(waddr) == 32'(wk) * 32'(N) - 32'd1;

    always_comb begin
        state_d = state_q;
        slot_st_d = slot_st_q;
        slot_k_d = slot_k_q;
        bank_k_d = bank_k_q;
        slot_src_d = slot_src_q;
        a_valid_d = a_valid_q;
        lslot_d = lslot_q;
        cslot_d = cslot_q;
        last_src_d = last_src_q;
        cur_src_d = cur_src_q;
        cur_k_d = cur_k_q;
        cnt_d = cnt_q;
        k_error_d = acc && idle && hdr_bad;
        if (wr) begin
            cur_k_d = wk;
            cur_src_d = wsrc;
            cnt_d = a_last ? '0 : waddr + 1'b1;
            state_d = b_last ? IDLE : (w_is_a && !a_last ? LOAD_A : LOAD_B);
            if (b_last) begin
                slot_st_d[lslot_q] = FULL;
                slot_src_d[lslot_q] = wsrc;
                slot_k_d[lslot_q] = wk;
                bank_k_d[wsrc] = wk;
                a_valid_d[wsrc] = 1'b1;
                last_src_d = wsrc;
                lslot_d = !lslot_q;
            end
        end
        // A finishing load always targets the FREE slot, so it never collides with this release.
        if (bus.compute_finished && loaded_q) begin
            slot_st_d[cslot_q] = FREE;
            cslot_d = !cslot_q;
        end
        loaded_d = slot_st_d[cslot_d] == FULL;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            slot_st_q <= '{FREE, FREE};
            slot_k_q <= '{default: '0};
            bank_k_q <= '{default: '0};
            slot_src_q <= '0;
            a_valid_q <= '0;
            lslot_q <= 1'b0;
            cslot_q <= 1'b0;
            last_src_q <= 1'b0;
            cur_src_q <= 1'b0;
            cur_k_q <= '0;
            cnt_q <= '0;
            loaded_q <= 1'b0;
            k_error_q <= 1'b0;
        end else begin
            state_q <= state_d;
            slot_st_q <= slot_st_d;
            slot_k_q <= slot_k_d;
            bank_k_q <= bank_k_d;
            slot_src_q <= slot_src_d;
            a_valid_q <= a_valid_d;
            lslot_q <= lslot_d;
            cslot_q <= cslot_d;
            last_src_q <= last_src_d;
            cur_src_q <= cur_src_d;
            cur_k_q <= cur_k_d;
            cnt_q <= cnt_d;
            loaded_q <= loaded_d;
            k_error_q <= k_error_d;
        end
    end

    input_mems_pp_mem #(.W(INW), .DEPTH(2 * M * MAXK)) u_a_mem (
        .clk(clk),
        .reset(reset),
        .we_i(wr && w_is_a),
        .waddr_i({wsrc, waddr[A_ADDR_BITS-1:0]}),
        .wdata_i(bus.AXIS_TDATA),
        .re_i(32'(bus.A_read_addr) < 32'(M * MAXK)),
        .raddr_i({slot_src_q[cslot_q], bus.A_read_addr}),
        .rdata_o(a_rdata)
    );

    input_mems_pp_mem #(.W(INW), .DEPTH(2 * MAXK * N)) u_b_mem (
        .clk(clk),
        .reset(reset),
        .we_i(wr && !w_is_a),
        .waddr_i({lslot_q, waddr[B_ADDR_BITS-1:0]}),
        .wdata_i(bus.AXIS_TDATA),
        .re_i(32'(bus.B_read_addr) < 32'(MAXK * N)),
        .raddr_i({cslot_q, bus.B_read_addr}),
        .rdata_o(b_rdata)
    );

    assign bus.AXIS_TREADY = rdy;
    assign bus.matrices_loaded = loaded_q;
    assign bus.K = slot_k_q[cslot_q];
    assign bus.A_data = a_rdata;
    assign bus.B_data = b_rdata;
`ifdef INPUT_MEMS_KCHECK_EN
    assign bus.k_error = k_error_q;
`endif
endmodule

// File: tb/tb_input_mems_pp.sv
// tb_input_mems_pp: scenario tasks for input_mems_pp; expected read data goes through a queue.
// Define INPUT_MEMS_KCHECK_EN to exercise header rejection instead of clamping.
module tb_input_mems_pp;
    localparam int INW = 12, M = 7, N = 9, MAXK = 8;
    localparam int K_BITS = $clog2(MAXK + 1);
    localparam int A_ADDR_BITS = $clog2(M * MAXK);
    localparam int B_ADDR_BITS = $clog2(MAXK * N);

    logic clk = 1'b0;
    logic reset = 1'b1;
    int checks = 0;
    int errors = 0;
    int exp_q[$];
    logic signed [INW-1:0] a_got, b_got;

    input_mems_pp_if #(.INW(INW), .K_BITS(K_BITS), .A_ADDR_BITS(A_ADDR_BITS), .B_ADDR_BITS(B_ADDR_BITS)) bus ();
    input_mems_pp #(.INW(INW), .M(M), .N(N), .MAXK(MAXK)) dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;

    task automatic send(input int d, input int k, input bit na, output int waits);
        waits = 0;
        bus.AXIS_TDATA = INW'(d);
        bus.AXIS_TUSER = {K_BITS'(k), na};
        bus.AXIS_TVALID = 1'b1;
        while (!bus.AXIS_TREADY && waits < 100) begin
            @(negedge clk);
            waits++;
        end
        if (!bus.AXIS_TREADY) begin
            checks++; errors++;
            $display("FAIL send_timeout: ready %0b after %0d cycles, required 1", bus.AXIS_TREADY, waits);
        end
        @(negedge clk);
        bus.AXIS_TVALID = 1'b0;
    endtask

    task automatic load(input int k, input bit na, input int n_a, input int n_b, input int abase, input int bbase, output int stalls);
        int w;
        stalls = 0;
        for (int i = 0; i < n_a + n_b; i++) begin
            send(i < n_a ? abase + i : bbase + i - n_a, k, na, w);
            stalls += w;
        end
    endtask

    task automatic rd(input int aa, input int ba);
        bus.A_read_addr = A_ADDR_BITS'(aa);
        bus.B_read_addr = B_ADDR_BITS'(ba);
        @(negedge clk);
        a_got = bus.A_data;
        b_got = bus.B_data;
    endtask

    task automatic finish_compute();
        bus.compute_finished = 1'b1;
        @(negedge clk);
        bus.compute_finished = 1'b0;
    endtask

    task automatic check_read(input string name, input int aa, input int ba, input int ea, input int eb);
        int e;
        exp_q.push_back(ea);
        exp_q.push_back(eb);
        rd(aa, ba);
        e = exp_q.pop_front();
        checks++;
        if (a_got !== INW'(e)) begin errors++; $display("FAIL %s_A[%0d]: got %0d required %0d", name, aa, a_got, e); end
        e = exp_q.pop_front();
        checks++;
        if (b_got !== INW'(e)) begin errors++; $display("FAIL %s_B[%0d]: got %0d required %0d", name, ba, b_got, e); end
    endtask

    task automatic test_reset();
        bus.AXIS_TDATA = '0; bus.AXIS_TUSER = '0; bus.AXIS_TVALID = 1'b0;
        bus.compute_finished = 1'b0; bus.A_read_addr = '0; bus.B_read_addr = '0;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        checks += 5;
        if (bus.AXIS_TREADY !== 1'b1) begin errors++; $display("FAIL reset_tready: got %0b required 1", bus.AXIS_TREADY); end
        if (bus.matrices_loaded !== 1'b0) begin errors++; $display("FAIL reset_loaded: got %0b required 0", bus.matrices_loaded); end
        if (bus.K !== '0) begin errors++; $display("FAIL reset_K: got %0d required 0", bus.K); end
        if (bus.A_data !== '0) begin errors++; $display("FAIL reset_A_data: got %0d required 0", bus.A_data); end
        if (bus.B_data !== '0) begin errors++; $display("FAIL reset_B_data: got %0d required 0", bus.B_data); end
    endtask

    task automatic test_basic();
        int st, w;
        load(3, 1'b1, 21, 26, 1, 101, st);
        checks++;
        if (bus.matrices_loaded !== 1'b0) begin errors++; $display("FAIL basic_early_loaded: got %0b required 0", bus.matrices_loaded); end
        send(127, 3, 1'b1, w);
        checks += 2;
        if (bus.matrices_loaded !== 1'b1) begin errors++; $display("FAIL basic_loaded: got %0b required 1", bus.matrices_loaded); end
        if (bus.K !== 4'd3) begin errors++; $display("FAIL basic_K: got %0d required 3", bus.K); end
        check_read("basic", 4, 26, 5, 127);
        check_read("basic", 0, 0, 1, 101);
        check_read("basic", 20, 13, 21, 114);
    endtask

    task automatic test_overlap();
        int st, stalled;
        load(2, 1'b1, 14, 18, 201, 301, st);
        checks += 2;
        if (st !== 0) begin errors++; $display("FAIL overlap_stalls: got %0d required 0", st); end
        if (bus.K !== 4'd3) begin errors++; $display("FAIL overlap_K_held: got %0d required 3", bus.K); end
        check_read("overlap_first", 4, 26, 5, 127);
        bus.AXIS_TDATA = INW'(401); bus.AXIS_TUSER = {K_BITS'(5), 1'b1}; bus.AXIS_TVALID = 1'b1;
        stalled = 0;
        repeat (4) begin
            if (bus.AXIS_TREADY === 1'b0) stalled++;
            @(negedge clk);
        end
        checks++;
        if (stalled !== 4) begin errors++; $display("FAIL overlap_third_stall: stalled %0d cycles required 4", stalled); end
        bus.AXIS_TVALID = 1'b0;
        finish_compute();
        checks += 3;
        if (bus.AXIS_TREADY !== 1'b1) begin errors++; $display("FAIL overlap_tready: got %0b required 1", bus.AXIS_TREADY); end
        if (bus.matrices_loaded !== 1'b1) begin errors++; $display("FAIL overlap_loaded: got %0b required 1", bus.matrices_loaded); end
        if (bus.K !== 4'd2) begin errors++; $display("FAIL overlap_K: got %0d required 2", bus.K); end
        check_read("overlap_second", 13, 17, 214, 318);
        check_read("overlap_second", 0, 0, 201, 301);
        load(5, 1'b1, 35, 45, 401, 501, st);
        finish_compute();
        checks++;
        if (bus.K !== 4'd5) begin errors++; $display("FAIL overlap_third_K: got %0d required 5", bus.K); end
        check_read("overlap_third", 34, 44, 435, 545);
        finish_compute();
        checks++;
        if (bus.matrices_loaded !== 1'b0) begin errors++; $display("FAIL overlap_drained: got %0b required 0", bus.matrices_loaded); end
    endtask

    task automatic test_reuse();
        int st;
        load(4, 1'b1, 28, 36, 601, 701, st);
        load(7, 1'b0, 0, 36, 0, 801, st);
        checks++;
        if (bus.AXIS_TREADY !== 1'b0) begin errors++; $display("FAIL reuse_word_count: tready %0b after 36 words, required 0", bus.AXIS_TREADY); end
        finish_compute();
        checks++;
        if (bus.K !== 4'd4) begin errors++; $display("FAIL reuse_K: got %0d required 4", bus.K); end
        check_read("reuse", 27, 35, 628, 836);
        load(2, 1'b1, 14, 18, 901, 1001, st);
        checks++;
        if (bus.K !== 4'd4) begin errors++; $display("FAIL reuse_K_kept: got %0d required 4", bus.K); end
        check_read("reuse_kept", 27, 35, 628, 836);
        check_read("reuse_kept", 5, 0, 606, 801);
        finish_compute();
        checks++;
        if (bus.K !== 4'd2) begin errors++; $display("FAIL reuse_third_K: got %0d required 2", bus.K); end
        check_read("reuse_third", 13, 17, 914, 1018);
        finish_compute();
    endtask

    task automatic test_collision();
        int st;
        load(1, 1'b1, 7, 9, 1101, 1201, st);
        load(1, 1'b1, 7, 8, 1301, 1401, st);
        bus.AXIS_TDATA = INW'(1409); bus.AXIS_TVALID = 1'b1; bus.compute_finished = 1'b1;
        @(negedge clk);
        bus.AXIS_TVALID = 1'b0; bus.compute_finished = 1'b0;
        checks += 2;
        if (bus.matrices_loaded !== 1'b1) begin errors++; $display("FAIL collision_loaded: got %0b required 1", bus.matrices_loaded); end
        if (bus.AXIS_TREADY !== 1'b1) begin errors++; $display("FAIL collision_tready: got %0b required 1", bus.AXIS_TREADY); end
        check_read("collision", 6, 8, 1307, 1409);
        finish_compute();
        checks++;
        if (bus.matrices_loaded !== 1'b0) begin errors++; $display("FAIL collision_drained: got %0b required 0", bus.matrices_loaded); end
    endtask

    task automatic test_reset_mid();
        int st;
        load(8, 1'b1, 10, 0, 1, 0, st);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        checks += 3;
        if (bus.AXIS_TREADY !== 1'b1) begin errors++; $display("FAIL midreset_tready: got %0b required 1", bus.AXIS_TREADY); end
        if (bus.matrices_loaded !== 1'b0) begin errors++; $display("FAIL midreset_loaded: got %0b required 0", bus.matrices_loaded); end
        if (bus.K !== '0) begin errors++; $display("FAIL midreset_K: got %0d required 0", bus.K); end
        load(3, 1'b1, 21, 27, 1501, 1601, st);
        checks++;
        if (bus.K !== 4'd3) begin errors++; $display("FAIL midreset_reload_K: got %0d required 3", bus.K); end
        check_read("midreset", 20, 26, 1521, 1627);
        check_read("midreset", 0, 0, 1501, 1601);
        finish_compute();
    endtask

    task automatic test_kcheck();
        int st, w;
`ifdef INPUT_MEMS_KCHECK_EN
        send(7, 9, 1'b1, w);
        checks += 2;
        if (bus.k_error !== 1'b1) begin errors++; $display("FAIL kcheck_pulse: got %0b required 1", bus.k_error); end
        if (bus.AXIS_TREADY !== 1'b1) begin errors++; $display("FAIL kcheck_tready: got %0b required 1", bus.AXIS_TREADY); end
        @(negedge clk);
        checks++;
        if (bus.k_error !== 1'b0) begin errors++; $display("FAIL kcheck_pulse_end: got %0b required 0", bus.k_error); end
        load(8, 1'b1, 56, 71, 1, 100, st);
`else
        load(9, 1'b1, 56, 71, 1, 100, st);
`endif
        checks++;
        if (bus.matrices_loaded !== 1'b0) begin errors++; $display("FAIL kcheck_early_loaded: got %0b required 0", bus.matrices_loaded); end
        send(171, 9, 1'b1, w);
        checks += 2;
        if (bus.matrices_loaded !== 1'b1) begin errors++; $display("FAIL kcheck_loaded: got %0b required 1", bus.matrices_loaded); end
        if (bus.K !== 4'd8) begin errors++; $display("FAIL kcheck_K: got %0d required 8", bus.K); end
        check_read("kcheck", 55, 71, 56, 171);
        check_read("kcheck", 0, 0, 1, 100);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_overlap();
        test_reuse();
        test_collision();
        test_reset_mid();
        test_kcheck();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
